// File: rtl/mem_arbiter.sv
// mem_arbiter: single owner of the byte-wide RAM/IO port; arbitrates store > IO read > load > fetch.
// Optional MEM_ARB_IO_GAP_EN forces a mem_wr=0 cycle after every IO-region write beat (WGAP state).
//
// state | meaning
// IDLE  | waiting; grants highest-priority unmasked request
// RD    | issuing read addresses and capturing bytes (cnt = cycles since grant)
// WR    | issuing write beats (cnt = beats already written)
// WGAP  | one idle cycle after an IO write beat (MEM_ARB_IO_GAP_EN only)
module mem_arbiter #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [2:0]  st_size,
  input  logic [31:0] st_data,
  output logic        st_done,
  input  logic        io_req,
  input  logic [31:0] io_addr,
  input  logic [2:0]  io_size,
  output logic        io_done,
  output logic [31:0] io_data,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_size,
  output logic        ld_done,
  output logic [31:0] ld_data,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
`ifdef MEM_ARB_IO_GAP_EN
    , S_WGAP = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {OWN_ST, OWN_IO, OWN_LD, OWN_IF} owner_t;

  state_t      state, state_nx;
  owner_t      owner_q, owner_nx, g_owner;
  logic [2:0]  cnt, cnt_nx, beats_q, beats_nx, g_size, g_beats;
  logic [31:0] addr_q, addr_nx, g_addr, buf_q, buf_nx, buf_cap, wdata_q, wdata_nx;
  logic [31:0] mem_a_nx, io_data_nx, ld_data_nx, if_data_nx, r_addr;
  logic [7:0]  mem_dout_nx;
  logic        mem_wr_q, mem_wr_nx, st_done_nx, io_done_nx, ld_done_nx, if_done_nx;
  logic        st_ok, io_ok, ld_ok, if_ok, any_grant;
  logic [31:0] w_base, w_src, w_shift, w_addr;
  logic [2:0]  w_idx;
  logic        w_io, w_try, w_issue;

  function automatic logic [2:0] beats_of(input logic [2:0] size);
    case (size)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A requester whose done pulse is visible this cycle is still holding req; mask it.
  assign st_ok     = st_req & ~st_done;
  assign io_ok     = io_req & ~io_done & ~clear;
  assign ld_ok     = ld_req & ~ld_done & ~clear;
  assign if_ok     = if_req & ~if_done & ~clear;
  assign any_grant = st_ok | io_ok | ld_ok | if_ok;

  always_comb begin
    g_owner = OWN_IF;
    g_addr  = if_addr;
    g_size  = 3'd4;
    if (st_ok) begin
      g_owner = OWN_ST; g_addr = st_addr; g_size = st_size;
    end else if (io_ok) begin
      g_owner = OWN_IO; g_addr = io_addr; g_size = io_size;
    end else if (ld_ok) begin
      g_owner = OWN_LD; g_addr = ld_addr; g_size = ld_size;
    end
  end
  assign g_beats = beats_of(g_size);

  // The grant edge itself attempts write beat 0, so IDLE uses the live store inputs.
  assign w_base  = (state == S_IDLE) ? st_addr : addr_q;
  assign w_src   = (state == S_IDLE) ? st_data : wdata_q;
  assign w_idx   = (state == S_IDLE) ? 3'd0 : cnt;
  assign w_addr  = w_base + 32'(w_idx);
  assign w_shift = w_src >> {w_idx[1:0], 3'b000};
  assign w_io    = (w_base[17:16] == IO_HI);
  assign w_try   = (state == S_IDLE) ? st_ok : ((state == S_WR) && (cnt != beats_q));
  assign w_issue = w_try & ~(w_io & io_buffer_full);

  assign r_addr = addr_q + 32'(cnt) + 32'd1;

  always_comb begin
    buf_cap = buf_q;
    case (cnt)
      3'd1:    buf_cap[7:0]   = mem_din;
      3'd2:    buf_cap[15:8]  = mem_din;
      3'd3:    buf_cap[23:16] = mem_din;
      3'd4:    buf_cap[31:24] = mem_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= S_IDLE;
    else if (rdy) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (any_grant) begin
        state_nx = (g_owner == OWN_ST) ? S_WR : S_RD;
`ifdef MEM_ARB_IO_GAP_EN
        if (w_issue && w_io) state_nx = S_WGAP;
`endif
      end
      S_RD: if (clear || (cnt == beats_q)) state_nx = S_IDLE;
      S_WR: begin
        if (cnt == beats_q) state_nx = S_IDLE;
`ifdef MEM_ARB_IO_GAP_EN
        else if (w_issue && w_io) state_nx = S_WGAP;
      end
      S_WGAP: begin
        state_nx = (cnt == beats_q) ? S_IDLE : S_WR;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_nx      = cnt;
    addr_nx     = addr_q;
    beats_nx    = beats_q;
    owner_nx    = owner_q;
    buf_nx      = buf_q;
    wdata_nx    = wdata_q;
    mem_a_nx    = mem_a;
    mem_dout_nx = mem_dout;
    mem_wr_nx   = 1'b0;
    st_done_nx  = 1'b0;
    io_done_nx  = 1'b0;
    ld_done_nx  = 1'b0;
    if_done_nx  = 1'b0;
    io_data_nx  = io_data;
    ld_data_nx  = ld_data;
    if_data_nx  = if_data;
    case (state)
      S_IDLE: if (any_grant) begin
        addr_nx  = g_addr;
        beats_nx = g_beats;
        owner_nx = g_owner;
        buf_nx   = 32'd0;
        wdata_nx = st_data;
        cnt_nx   = 3'd0;
        mem_a_nx = g_addr;
      end
      S_RD: begin
        if (clear) begin
          cnt_nx = 3'd0;
        end else if (cnt == beats_q) begin
          cnt_nx = 3'd0;
          case (owner_q)
            OWN_IO:  begin io_done_nx = 1'b1; io_data_nx = buf_cap; end
            OWN_LD:  begin ld_done_nx = 1'b1; ld_data_nx = buf_cap; end
            default: begin if_done_nx = 1'b1; if_data_nx = buf_cap; end
          endcase
        end else begin
          cnt_nx = cnt + 3'd1;
          buf_nx = buf_cap;
          if ((cnt + 3'd1) < beats_q) mem_a_nx = r_addr;
        end
      end
      default: if (cnt == beats_q) begin
        st_done_nx = 1'b1;
        cnt_nx     = 3'd0;
      end
    endcase
    if (w_issue) begin
      mem_a_nx    = w_addr;
      mem_dout_nx = w_shift[7:0];
      mem_wr_nx   = 1'b1;
      cnt_nx      = w_idx + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 3'd0;
      addr_q   <= 32'd0;
      beats_q  <= 3'd0;
      owner_q  <= OWN_ST;
      buf_q    <= 32'd0;
      wdata_q  <= 32'd0;
      mem_a    <= 32'd0;
      mem_dout <= 8'd0;
      mem_wr_q <= 1'b0;
      st_done  <= 1'b0;
      io_done  <= 1'b0;
      ld_done  <= 1'b0;
      if_done  <= 1'b0;
      io_data  <= 32'd0;
      ld_data  <= 32'd0;
      if_data  <= 32'd0;
    end else if (rdy) begin
      cnt      <= cnt_nx;
      addr_q   <= addr_nx;
      beats_q  <= beats_nx;
      owner_q  <= owner_nx;
      buf_q    <= buf_nx;
      wdata_q  <= wdata_nx;
      mem_a    <= mem_a_nx;
      mem_dout <= mem_dout_nx;
      mem_wr_q <= mem_wr_nx;
      st_done  <= st_done_nx;
      io_done  <= io_done_nx;
      ld_done  <= ld_done_nx;
      if_done  <= if_done_nx;
      io_data  <= io_data_nx;
      ld_data  <= ld_data_nx;
      if_data  <= if_data_nx;
    end
  end

  assign mem_wr = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, clear = 1'b0;
  logic st_req = 1'b0, io_req = 1'b0, ld_req = 1'b0, if_req = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, io_addr = '0, ld_addr = '0, if_addr = '0;
  logic [2:0]  st_size = '0, io_size = '0, ld_size = '0;
  logic        st_done, io_done, ld_done, if_done, mem_wr;
  logic [31:0] io_data, ld_data, if_data, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'h00;
  logic        io_buffer_full = 1'b0;
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [7:0]  ram [0:4095] = '{default: 8'h00};
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_done(st_done),
    .io_req(io_req), .io_addr(io_addr), .io_size(io_size), .io_done(io_done), .io_data(io_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    else if (poke_en) ram[poke_addr] <= poke_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    tick();
    poke_en = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b0;
    #20;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h0);
    check("rst_dones", {st_done, io_done, ld_done, if_done}, 4'h0);
    check("rst_data", io_data | ld_data | if_data, 32'h0);
    poke(12'h100, 8'h13); poke(12'h101, 8'h05); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
    poke(12'h003, 8'h80);
    rst = 1'b1;
    tick();

    // fetch of 0x100
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check("fetch_a0", mem_a, 32'h100);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("fetch_ak", mem_a, 32'h100 + k);
    end
    tick();
    check("fetch_done_early", if_done, 1'b0);
    tick();
    check("fetch_done", if_done, 1'b1);
    check("fetch_data", if_data, 32'h0000_0513);
    tick();
    check("fetch_masked", mem_a, 32'h103);
    check("fetch_pulse", if_done, 1'b0);

    // store beats fetch
    st_req = 1'b1; st_addr = 32'h200; st_size = 3'd4; st_data = 32'hDEAD_BEEF;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("sw_a", mem_a, 32'h200 + k);
      check("sw_dout", mem_dout, (32'hDEAD_BEEF >> (8 * k)) & 32'hFF);
      check("sw_wr", mem_wr, 1'b1);
      tick();
    end
    check("sw_done", st_done, 1'b1);
    check("sw_wr_off", mem_wr, 1'b0);
    tick();
    st_req = 1'b0;
    check("sw_then_fetch", mem_a, 32'h100);
    check("sw_done_pulse", st_done, 1'b0);
    check("sw_ram", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]}, 32'hDEAD_BEEF);
    repeat (5) tick();
    check("fetch2_done", if_done, 1'b1);
    check("fetch2_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();

    // byte load, zero extended
    ld_req = 1'b1; ld_size = 3'd1; ld_addr = 32'h1003;
    tick();
    check("lb_a", mem_a, 32'h1003);
    tick();
    check("lb_done_early", ld_done, 1'b0);
    tick();
    check("lb_done", ld_done, 1'b1);
    check("lb_data", ld_data, 32'h0000_0080);
    ld_req = 1'b0;
    tick();

    // IO read beats load, halfword
    io_req = 1'b1; io_addr = 32'h200; io_size = 3'd2;
    ld_req = 1'b1; ld_addr = 32'h100; ld_size = 3'd4;
    tick();
    check("io_a0", mem_a, 32'h200);
    tick(); tick();
    check("io_done_early", io_done, 1'b0);
    tick();
    check("io_done", io_done, 1'b1);
    check("io_data", io_data, 32'h0000_BEEF);
    tick();
    io_req = 1'b0;
    check("ld_after_io", mem_a, 32'h100);
    ld_req = 1'b0;
    repeat (5) tick();
    check("lw_done", ld_done, 1'b1);
    check("lw_data", ld_data, 32'h0000_0513);
    tick();

    // clear aborts a load, pending fetch proceeds
    ld_req = 1'b1; ld_addr = 32'h100; ld_size = 3'd4;
    if_req = 1'b1; if_addr = 32'h200;
    tick();
    check("clr_ld_a", mem_a, 32'h100);
    clear = 1'b1; ld_req = 1'b0;
    tick();
    clear = 1'b0;
    check("clr_ld_nodone", ld_done, 1'b0);
    tick();
    check("clr_fetch_a", mem_a, 32'h200);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("clr_no_ld_done", ld_done, 1'b0);
      check("clr_no_wr", mem_wr, 1'b0);
    end
    tick();
    check("clr_fetch_done", if_done, 1'b1);
    check("clr_fetch_data", if_data, 32'hDEAD_BEEF);
    check("clr_ld_still_none", ld_done, 1'b0);
    if_req = 1'b0;
    tick();

    // clear does not stop a committed store
    st_req = 1'b1; st_addr = 32'h300; st_size = 3'd4; st_data = 32'h1122_3344;
    tick();
    check("clr_sw_b0", mem_dout, 8'h44);
    tick();
    clear = 1'b1;
    check("clr_sw_b1", mem_dout, 8'h33);
    tick();
    clear = 1'b0;
    check("clr_sw_b2", {mem_wr, mem_a[11:0], mem_dout}, {1'b1, 12'h302, 8'h22});
    tick();
    check("clr_sw_b3", {mem_wr, mem_a[11:0], mem_dout}, {1'b1, 12'h303, 8'h11});
    tick();
    check("clr_sw_done", st_done, 1'b1);
    st_req = 1'b0;
    tick();
    check("clr_sw_ram", {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]}, 32'h1122_3344);

    // IO store stalled by full buffer
    io_buffer_full = 1'b1;
    st_req = 1'b1; st_addr = 32'h3_0000; st_size = 3'd1; st_data = 32'h41;
    tick();
    check("stall_c0", mem_wr, 1'b0);
    tick();
    check("stall_c1", mem_wr, 1'b0);
    tick();
    check("stall_c2", mem_wr, 1'b0);
    io_buffer_full = 1'b0;
    tick();
    check("stall_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h3_0000, 8'h41});
    tick();
    check("stall_done", {st_done, mem_wr}, 2'b10);
    st_req = 1'b0;
    tick();
    check("stall_ram", ram[12'h000], 8'h41);

`ifdef MEM_ARB_IO_GAP_EN
    st_req = 1'b1; st_addr = 32'h3_0000; st_size = 3'd2; st_data = 32'h4443;
    tick();
    check("gap_b0", {mem_wr, mem_dout}, {1'b1, 8'h43});
    tick();
    check("gap_idle", mem_wr, 1'b0);
    tick();
    check("gap_b1", {mem_wr, mem_dout}, {1'b1, 8'h44});
    tick();
    check("gap_done", st_done, 1'b1);
    st_req = 1'b0;
    tick();
`endif

    // rdy freeze, then asynchronous reset mid-read
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check("frz_a0", mem_a, 32'h100);
    rdy = 1'b0;
    tick(); tick();
    check("frz_hold", mem_a, 32'h100);
    rdy = 1'b1;
    tick();
    check("frz_resume", mem_a, 32'h101);
    #2 rst = 1'b0;
    #1;
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_data", if_data | ld_data | io_data, 32'h0);
    check("arst_ctl", {mem_wr, mem_dout, st_done, if_done}, 11'h0);
    if_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // clear in IDLE blocks a load grant
    ld_req = 1'b1; ld_addr = 32'h100; ld_size = 3'd4; clear = 1'b1;
    tick();
    check("clr_idle_nogrant", mem_a, 32'h0);
    ld_req = 1'b0; clear = 1'b0;
    tick(); tick();
    check("clr_idle_nodone", ld_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single owner of the CPU2021 byte-wide RAM/IO port.
- Arbitrates four requesters:
  - ROB committed store (st_*), issued at ROB commit.
  - ROB head IO read (io_*).
  - LSB speculative load (ld_*).
  - Instruction fetch (if_*).
- Serialises each granted transaction into 1/2/4 byte beats and returns a one-cycle done pulse with assembled data.
- Sits between rob/lsb/fetcher and the top-level mem_a/mem_din/mem_dout/mem_wr pins.

Parameters:
- IO_HI, 2'b11: addr[17:16] value marking the IO region (0x30000+).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state.
- clear  in  1  flush (mispredict), synchronous.
- st_req  in  1  store request (level, held until st_done).
- st_addr  in  32  store byte address.
- st_size  in  3  store size in bytes: 1, 2 or 4.
- st_data  in  32  store data.
- st_done  out  1  store complete pulse.
- io_req  in  1  IO read request.
- io_addr  in  32  IO read address.
- io_size  in  3  IO read size.
- io_done  out  1  IO read done pulse.
- io_data  out  32  IO read data.
- ld_req  in  1  load request.
- ld_addr  in  32  load address.
- ld_size  in  3  load size.
- ld_done  out  1  load done pulse.
- ld_data  out  32  load data, zero-extended.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch address.
- if_done  out  1  fetch done pulse.
- if_data  out  32  fetched instruction.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM address.
- mem_wr  out  1  RAM write enable.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0.
  - All outputs 0: done pulses, data outputs, mem_a, mem_dout, mem_wr.
- rdy=0: no register updates; mem_wr output = mem_wr_q & rdy.
- States:
  - IDLE: grant on a clock edge with the highest-priority asserted request.
    - Priority: st > io > ld > if.
    - Latch addr, size, owner; go to RD or WR.
    - A requester whose done is high in the current cycle is masked for that edge.
  - RD, n = size beats, beat k at addr+k:
    - mem_a driven addr+k in cycle k after grant (k=0..n-1).
    - Byte for the address driven in cycle c is captured from mem_din at the end of cycle c+1.
    - Captured byte k goes to data[8k+7:8k], little-endian; unfetched upper bytes are 0.
    - After the last capture: owner's done=1 and owner's data valid in the next cycle, return to IDLE.
    - Grant edge to done edge = n+2 edges.
  - WR:
    - Each cycle drive mem_a=addr+k, mem_dout=st_data[8k+7:8k], mem_wr=1, k=0..n-1.
    - Then mem_wr=0 and st_done=1 in the next cycle; return to IDLE.
    - Grant edge to st_done edge = n+1 edges.
- IO store stall: when st_addr[17:16]==IO_HI and io_buffer_full=1, the WR beat is not issued.
  - mem_wr=0, cnt holds.
  - Resumes on the first cycle with io_buffer_full=0.
- Size decode: 1→1 beat, 2→2 beats, any other value→4 beats.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- Data outputs hold their last value until the next done for that owner.
- Done pulses are exactly 1 cycle, at most one owner per cycle.
- clear=1 at an edge:
  - In RD (any reader): abort. Next state IDLE, no done, capture counter reset.
  - In WR: the store continues to completion and st_done is still issued (committed store).
  - In IDLE: ld/if/io requests present that edge are not granted.
- Simultaneous clear and last read capture: the abort wins, no done.
- mem_wr is never 1 in RD or IDLE.

Optional Feature:
- Macro: MEM_ARB_IO_GAP_EN.
- Defined:
  - After any WR beat to the IO region, at least one cycle with mem_wr=0 is inserted before the next IO-region write beat.
  - This also applies across back-to-back stores.
  - Adds one state WGAP (one cycle, then IDLE or continue WR).
- Undefined: no gap; IO writes are limited only by io_buffer_full.

Test Plan:
- Fetch: if_req, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 → mem_a 0x100..0x103 on successive cycles; if_done on edge 6 after grant; if_data=0x00000513.
- Priority: st_req (SW, 0x200, 0xDEADBEEF) and if_req asserted together → 4 write cycles at 0x200..0x203 with bytes EF,BE,AD,DE, mem_wr=1; then st_done; fetch granted on the following edge.
- Load size: ld_req, ld_size=1, ld_addr=0x1003, RAM[0x1003]=0x80 → ld_data=0x00000080 (zero-extended); ld_done 3 edges after grant.
- Clear during load: clear pulsed 1 cycle after ld grant (LW) → no ld_done ever; mem_wr=0 throughout; a pending if_req is granted 2 edges later and completes normally.
- Clear during store: clear pulsed during beat 1 of SW to 0x300 → all 4 bytes written, st_done asserted.
- IO stall: SB to 0x30000 data 0x41 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 for 3 cycles; single write of 0x41 on the cycle after full drops; st_done next.
- Reset mid-read: rst=0 asynchronously during RD → all outputs 0 immediately (before the next edge), state IDLE.
  - With MEM_ARB_IO_GAP_EN: two SB to 0x30000 back-to-back → ≥1 cycle with mem_wr=0 between the two write beats.
